// File: rtl/sdr_rd_fsm.sv
// -----------------------------------------------------------------------------
// sdr_rd_fsm
//
// Single-access SDRAM read sequencer. For one request it drives ACTIVE, waits
// tRCD, issues READ with auto-precharge, waits out the CAS latency, captures a
// two-beat burst from the DQ pins and hands back one 32-bit word. A recovery
// window of TRP cycles follows before the next request is accepted.
//
// Parameters:
//   TRCD  cycles from ACTIVE to READ on the bus (1..7)
//   CL    CAS latency of the SDRAM mode register (2 or 3)
//   TRP   recovery cycles after the burst before IDLE (1..7)
//
// Ports:
//   clk         controller clock
//   soft_rst_n  asynchronous active-low reset
//   rd_en       read request, sampled only in IDLE
//   row/col/ba  address; row/ba taken at the ACTIVE edge, col at the READ edge
//   dq_in       SDRAM DQ pins, input side
//   rd_bus      command/address bus {cmd[3:0], a[12:0], ba[1:0], cke}
//   rdata       assembled word {second beat, first beat}
//   rd_done     one-cycle pulse; rdata valid from this cycle onward
//   rd_busy     high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module sdr_rd_fsm #(
    parameter int TRCD = 2,
    parameter int CL   = 2,
    parameter int TRP  = 2
) (
    input  logic        clk,
    input  logic        soft_rst_n,
    input  logic        rd_en,
    input  logic [12:0] row,
    input  logic [9:0]  col,
    input  logic [1:0]  ba,
    input  logic [15:0] dq_in,
    output logic [19:0] rd_bus,
    output logic [31:0] rdata,
    output logic        rd_done,
    output logic        rd_busy
);

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACT_WAIT = 3'd1;
    localparam logic [2:0] S_CAS_WAIT = 3'd2;
    localparam logic [2:0] S_CAP_LO   = 3'd3;
    localparam logic [2:0] S_CAP_HI   = 3'd4;
    localparam logic [2:0] S_RECOV    = 3'd5;

    // Terminal counts: each wait state spends (last + 1) edges, the final one
    // being the edge that leaves the state.
    localparam logic [2:0] TRCD_LAST = 3'(TRCD - 1);
    localparam logic [2:0] CL_LAST   = 3'(CL - 1);
    localparam logic [2:0] TRP_LAST  = 3'(TRP - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [12:0] a_q, a_d;
    logic [1:0]  ba_q, ba_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_done_q, rd_done_d;
    logic        rd_busy_q, rd_busy_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold it.
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = CMD_NOP;      // NOP unless a command is issued this edge
        a_d       = a_q;
        ba_d      = ba_q;
        lo_d      = lo_q;
        rdata_d   = rdata_q;
        rd_done_d = 1'b0;         // pulse: only CAP_HI raises it
        rd_busy_d = rd_busy_q;

        case (state_q)
            S_IDLE: begin
                if (rd_en) begin
                    cmd_d     = CMD_ACT;
                    a_d       = row;
                    ba_d      = ba;
                    rd_busy_d = 1'b1;
                    cnt_d     = 3'd0;
                    state_d   = S_ACT_WAIT;
                end
            end

            S_ACT_WAIT: begin
                if (cnt_q == TRCD_LAST) begin
                    // a[10] set selects auto-precharge; bank stays as opened.
                    cmd_d   = CMD_RD;
                    a_d     = {2'b00, 1'b1, col};
                    cnt_d   = 3'd0;
                    state_d = S_CAS_WAIT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_CAS_WAIT: begin
                if (cnt_q == CL_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = S_CAP_LO;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_CAP_LO: begin
                lo_d    = dq_in;
                state_d = S_CAP_HI;
            end

            S_CAP_HI: begin
                rdata_d   = {dq_in, lo_q};
                rd_done_d = 1'b1;
                cnt_d     = 3'd0;
                state_d   = S_RECOV;
            end

            S_RECOV: begin
                if (cnt_q == TRP_LAST) begin
                    rd_busy_d = 1'b0;
                    cnt_d     = 3'd0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            default: begin
                rd_busy_d = 1'b0;
                cnt_d     = 3'd0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge soft_rst_n) begin
        if (!soft_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            cmd_q     <= CMD_NOP;
            a_q       <= 13'd0;
            ba_q      <= 2'd0;
            lo_q      <= 16'd0;
            rdata_q   <= 32'd0;
            rd_done_q <= 1'b0;
            rd_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            a_q       <= a_d;
            ba_q      <= ba_d;
            lo_q      <= lo_d;
            rdata_q   <= rdata_d;
            rd_done_q <= rd_done_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    // cke is tied high; the rest of the bus comes straight from flops.
    assign rd_bus  = {cmd_q, a_q, ba_q, 1'b1};
    assign rdata   = rdata_q;
    assign rd_done = rd_done_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_sdr_rd_fsm.sv
// -----------------------------------------------------------------------------
// tb_sdr_rd_fsm
//
// Drives two sequencers in parallel from the same stimulus: u0 with default
// timing (TRCD=2, CL=2, TRP=2) and u1 with TRCD=3, CL=3, TRP=2. A timeline
// model derives the expected outputs of each from the cycle offset relative
// to the accepted request, and is compared on every falling edge. Directed
// literal checks pin the model at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_sdr_rd_fsm;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;

    logic        clk = 1'b0;
    logic        soft_rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [12:0] row = 13'd0;
    logic [9:0]  col = 10'd0;
    logic [1:0]  ba = 2'd0;
    logic [15:0] dq_in = 16'd0;

    logic [19:0] bus0, bus1;
    logic [31:0] rdata0, rdata1;
    logic        done0, done1, busy0, busy1;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sdr_rd_fsm #(.TRCD(2), .CL(2), .TRP(2)) u0 (
        .clk(clk), .soft_rst_n(soft_rst_n), .rd_en(rd_en), .row(row), .col(col),
        .ba(ba), .dq_in(dq_in), .rd_bus(bus0), .rdata(rdata0), .rd_done(done0),
        .rd_busy(busy0)
    );

    sdr_rd_fsm #(.TRCD(3), .CL(3), .TRP(2)) u1 (
        .clk(clk), .soft_rst_n(soft_rst_n), .rd_en(rd_en), .row(row), .col(col),
        .ba(ba), .dq_in(dq_in), .rd_bus(bus1), .rdata(rdata1), .rd_done(done1),
        .rd_busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    // For an accepted request at edge E0, with r = edge - E0:
    //   r == 0             ACT with row/ba
    //   r == TRCD          RD with col, auto-precharge
    //   r == TRCD+CL+1     first beat sampled
    //   r == TRCD+CL+2     rdata updated, rd_done pulse
    //   busy over 0 <= r < TRCD+CL+2+TRP
    int          m_trcd[2] = '{2, 3};
    int          m_cl[2]   = '{2, 3};
    int          m_trp[2]  = '{2, 2};
    int          cyc = 0;
    bit          m_act[2];
    int          m_e0[2];
    logic [3:0]  e_cmd[2];
    logic [12:0] e_a[2];
    logic [1:0]  e_ba[2];
    logic [15:0] m_w1[2];
    logic [31:0] e_rdata[2];
    logic        e_done[2];
    logic        e_busy[2];

    always @(posedge clk or negedge soft_rst_n) begin
        if (!soft_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0;  m_e0[i] = 0;    e_cmd[i] = NOP;
                e_a[i] = 13'd0;   e_ba[i] = 2'd0; m_w1[i] = 16'd0;
                e_rdata[i] = 32'd0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                int r;
                if (m_act[i] && (cyc - m_e0[i] == m_trcd[i] + m_cl[i] + 2 + m_trp[i]))
                    m_act[i] = 1'b0;
                else if (!m_act[i] && rd_en) begin
                    m_act[i] = 1'b1;
                    m_e0[i]  = cyc;
                end
                r = cyc - m_e0[i];
                e_cmd[i]  = NOP;
                e_done[i] = 1'b0;
                if (m_act[i]) begin
                    if (r == 0) begin
                        e_cmd[i] = ACT; e_a[i] = row; e_ba[i] = ba;
                    end
                    if (r == m_trcd[i]) begin
                        e_cmd[i] = RD; e_a[i] = {3'b001, col};
                    end
                    if (r == m_trcd[i] + m_cl[i] + 1)
                        m_w1[i] = dq_in;
                    if (r == m_trcd[i] + m_cl[i] + 2) begin
                        e_rdata[i] = {dq_in, m_w1[i]};
                        e_done[i]  = 1'b1;
                    end
                end
                e_busy[i] = m_act[i];
            end
        end
    end

    task automatic cmp_inst(input int i, input logic [19:0] b, input logic [31:0] rd,
                            input logic dn, input logic bz);
        check($sformatf("u%0d rd_bus cyc %0d", i, cyc), {12'd0, b},
              {12'd0, e_cmd[i], e_a[i], e_ba[i], 1'b1});
        check($sformatf("u%0d rdata cyc %0d", i, cyc), rd, e_rdata[i]);
        check($sformatf("u%0d rd_done cyc %0d", i, cyc), {31'd0, dn}, {31'd0, e_done[i]});
        check($sformatf("u%0d rd_busy cyc %0d", i, cyc), {31'd0, bz}, {31'd0, e_busy[i]});
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, bus0, rdata0, done0, busy0);
            cmp_inst(1, bus1, rdata1, done1, busy1);
        end
    end

    // ---------------- directed scenarios ----------------
    function automatic logic [19:0] bus_of(input logic [3:0] c, input logic [12:0] a,
                                           input logic [1:0] b);
        return {c, a, b, 1'b1};
    endfunction

    // One isolated read, entered at a falling edge with the sequencers idle.
    // Beats lo/hi are presented at E5/E6 (u0) and repeated at E7/E8 (u1).
    task automatic do_read(input logic [12:0] r_row, input logic [9:0] r_col,
                           input logic [1:0] r_ba, input logic [15:0] lo,
                           input logic [15:0] hi, input string tag);
        rd_en = 1'b1; row = r_row; col = r_col; ba = r_ba;
        @(negedge clk);                      // E0 has passed
        rd_en = 1'b0;
        check({tag, " ACT u0"}, {12'd0, bus0}, {12'd0, bus_of(ACT, r_row, r_ba)});
        check({tag, " busy rise"}, {31'd0, busy0}, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            if (k == 5 || k == 7)      dq_in = lo;
            else if (k == 6 || k == 8) dq_in = hi;
            else                       dq_in = 16'($urandom);
            @(negedge clk);                  // Ek has passed
            if (k == 1) check({tag, " NOP E1"}, {12'd0, bus0}, {12'd0, bus_of(NOP, r_row, r_ba)});
            if (k == 2) check({tag, " RD u0"}, {12'd0, bus0},
                              {12'd0, bus_of(RD, {3'b001, r_col}, r_ba)});
            if (k == 3) check({tag, " RD u1"}, {12'd0, bus1},
                              {12'd0, bus_of(RD, {3'b001, r_col}, r_ba)});
            if (k == 5) check({tag, " no early done"}, {31'd0, done0}, 32'd0);
            if (k == 6) begin
                check({tag, " rdata u0"}, rdata0, {hi, lo});
                check({tag, " done u0"}, {31'd0, done0}, 32'd1);
            end
            if (k == 7) begin
                check({tag, " done u0 one cycle"}, {31'd0, done0}, 32'd0);
                check({tag, " busy u0 E7"}, {31'd0, busy0}, 32'd1);
            end
            if (k == 8) begin
                check({tag, " busy u0 fall"}, {31'd0, busy0}, 32'd0);
                check({tag, " rdata u1"}, rdata1, {hi, lo});
                check({tag, " done u1"}, {31'd0, done1}, 32'd1);
            end
            if (k == 9)  check({tag, " busy u1 E9"}, {31'd0, busy1}, 32'd1);
            if (k == 10) check({tag, " busy u1 fall"}, {31'd0, busy1}, 32'd0);
        end
    endtask

    initial begin
        int pulses;

        // Reset values, then idle with rd_en low.
        repeat (3) @(negedge clk);
        soft_rst_n = 1'b1;
        cmp_en = 1'b1;
        check("reset bus", {12'd0, bus0}, 32'h0007_0001);
        check("reset rdata", rdata0, 32'd0);
        check("reset done/busy", {30'd0, done0, busy0}, 32'd0);
        repeat (6) @(negedge clk);
        check("idle bus stays NOP", {12'd0, bus0}, 32'h0007_0001);

        // Single read at defaults and at TRCD=3/CL=3.
        do_read(13'h0ABC, 10'h155, 2'b10, 16'h1234, 16'h5678, "single");

        // rdata must hold with random DQ activity and no request.
        for (int k = 0; k < 10; k++) begin
            dq_in = 16'($urandom);
            @(negedge clk);
        end
        check("hold rdata u0", rdata0, 32'h5678_1234);
        check("hold rdata u1", rdata1, 32'h5678_1234);
        check("hold done", {31'd0, done0}, 32'd0);

        // Back-to-back: rd_en held high; second ACT at E9, two pulses in 18 edges.
        pulses = 0;
        rd_en = 1'b1; row = 13'h0123; col = 10'h2AA; ba = 2'b01;
        for (int k = 0; k < 18; k++) begin
            dq_in = 16'($urandom);
            @(negedge clk);                  // Ek has passed
            if (done0) pulses++;
            if (k == 8) check("b2b idle slot E8", {12'd0, bus0},
                              {12'd0, bus_of(NOP, {3'b001, 10'h2AA}, 2'b01)});
            if (k == 9) check("b2b second ACT E9", {12'd0, bus0},
                              {12'd0, bus_of(ACT, 13'h0123, 2'b01)});
        end
        check("b2b rd_done pulses", pulses, 32'd2);
        rd_en = 1'b0;
        repeat (14) @(negedge clk);

        // Abort between E3 and E4 of a read.
        rd_en = 1'b1; row = 13'h0F0F; col = 10'h0F0; ba = 2'b11;
        @(negedge clk);                      // E0
        rd_en = 1'b0;
        repeat (3) @(negedge clk);           // E1..E3
        #1 soft_rst_n = 1'b0;
        #1;
        check("abort bus NOP now", {12'd0, bus0}, 32'h0007_0001);
        check("abort busy now", {31'd0, busy0}, 32'd0);
        check("abort rdata 0", rdata0, 32'd0);
        repeat (3) @(negedge clk);
        check("abort no done", {30'd0, done0, done1}, 32'd0);
        check("abort rdata u1 0", rdata1, 32'd0);
        soft_rst_n = 1'b1;
        @(negedge clk);

        // Normal operation after the abort, with all-ones address fields.
        do_read(13'h1FFF, 10'h3FF, 2'b01, 16'hAAAA, 16'h5555, "post-abort");
        repeat (4) @(negedge clk);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
